set_assoc_cache_lru: RTL and testbench

//  Fully synchronous N-way set-associative cache level with a per-set true-LRU replacement policy.

---
 rtl/set_assoc_cache_lru_if.sv | 40 ++++
 rtl/set_assoc_cache_lru.sv | 181 ++++++++++++++++++
 tb/tb_set_assoc_cache_lru.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/set_assoc_cache_lru_if.sv
// Request and next-level bus for set_assoc_cache_lru.
//  Requester side : enable, we, addr_in, data_in -> cache; data_out, found_data, miss, busy <- cache
//  Next-level side: mem_req, mem_we, mem_addr, mem_wdata <- cache; mem_rdata, mem_done -> cache
//  Statistics     : hit_count, miss_count <- cache
//  slave  : the view used by the cache itself
//  master : the view used by whatever drives requests and models the next level
interface set_assoc_cache_lru_if #(
  parameter int ADDR_LENGTH = 10,
  parameter int BLOCK_SIZE  = 32,
  parameter int STAT_W      = 16
);
  logic                   enable;
  logic                   we;
  logic [ADDR_LENGTH-1:0] addr_in;
  logic [BLOCK_SIZE-1:0]  data_in;
  logic [BLOCK_SIZE-1:0]  data_out;
  logic                   found_data;
  logic                   miss;
  logic                   busy;
  logic                   mem_req;
  logic                   mem_we;
  logic [ADDR_LENGTH-1:0] mem_addr;
  logic [BLOCK_SIZE-1:0]  mem_wdata;
  logic [BLOCK_SIZE-1:0]  mem_rdata;
  logic                   mem_done;
  logic [STAT_W-1:0]      hit_count;
  logic [STAT_W-1:0]      miss_count;

  modport slave (
    input  enable, we, addr_in, data_in, mem_rdata, mem_done,
    output data_out, found_data, miss, busy, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );

  modport master (
    output enable, we, addr_in, data_in, mem_rdata, mem_done,
    input  data_out, found_data, miss, busy, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/set_assoc_cache_lru.sv
// N-way set-associative cache level, one word per line, true-LRU replacement per set.
// Write-through with no-write-allocate; read misses refill through mem_req/mem_done.
// Ports:
//  clk    clock, all state on posedge
//  reset  synchronous, active-high; clears control, valid bits, ages, counters, data_out
//  bus    set_assoc_cache_lru_if.slave: request strobe/address/data, completion pulses,
//         next-level handshake and saturating hit/miss counters
module set_assoc_cache_lru #(
  parameter int SIZE          = 128,
  parameter int ADDR_LENGTH   = 10,
  parameter int DELAY         = 10,
  parameter int BLOCK_SIZE    = 32,
  parameter int ASSOCIATIVITY = 4,
  parameter int STAT_W        = 16
) (
  input logic                 clk,
  input logic                 reset,
  set_assoc_cache_lru_if.slave bus
);
  localparam int SETS     = SIZE / BLOCK_SIZE;
  localparam int BYTE_SEL = $clog2(BLOCK_SIZE / 8);
  localparam int INDEX    = $clog2(SETS);
  localparam int TAG_W    = ADDR_LENGTH - INDEX - BYTE_SEL;
  localparam int AGE_W    = $clog2(ASSOCIATIVITY);
  localparam int CNT_W    = $clog2(DELAY + 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM} state_t;
  typedef logic [ASSOCIATIVITY-1:0][AGE_W-1:0] ages_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_LENGTH-1:0] addr_p0;
  logic                   we_p0;
  logic [BLOCK_SIZE-1:0]  data_p0;

  logic [SETS-1:0][ASSOCIATIVITY-1:0] valid_q;
  ages_t                  age_q    [SETS];
  logic [TAG_W-1:0]       tag_arr  [SETS][ASSOCIATIVITY];
  logic [BLOCK_SIZE-1:0]  line_arr [SETS][ASSOCIATIVITY];

  logic [BLOCK_SIZE-1:0]  data_out_q;
  logic                   found_q, miss_q, mem_req_q, mem_we_q;
  logic [STAT_W-1:0]      hit_cnt_q, miss_cnt_q;

  logic [INDEX-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic [AGE_W-1:0]       hit_way, victim, oldest;
  logic                   have_invalid;
  logic                   lookup_done;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
    return (&c) ? c : c + STAT_W'(1);
  endfunction

  // Ways younger than w age by one, w becomes the youngest; keeps ages a permutation.
  function automatic ages_t touch(input ages_t a, input logic [AGE_W-1:0] w);
    ages_t r;
    r = a;
    for (int i = 0; i < ASSOCIATIVITY; i++)
      if (a[i] < a[w]) r[i] = a[i] + AGE_W'(1);
    r[w] = '0;
    return r;
  endfunction

  assign idx         = addr_p0[BYTE_SEL +: INDEX];
  assign tag         = addr_p0[ADDR_LENGTH-1 -: TAG_W];
  assign lookup_done = (state_q == LOOKUP) && (cnt_q == CNT_W'(DELAY));

  // Descending scans so the lowest matching index wins.
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    have_invalid = 1'b0;
    oldest       = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_arr[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_q[idx][w]) have_invalid = 1'b1;
      if (age_q[idx][w] == AGE_W'(ASSOCIATIVITY - 1)) oldest = AGE_W'(w);
    end
    victim = oldest;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim = AGE_W'(w);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable) state_d = LOOKUP;
      LOOKUP:  if (lookup_done) state_d = (hit && !we_p0) ? IDLE : MEM;
      MEM:     if (bus.mem_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control, status and replacement state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out_q <= '0;
      found_q    <= 1'b0;
      miss_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < ASSOCIATIVITY; w++)
          age_q[s][w] <= AGE_W'(w);
    end else begin
      state_q <= state_d;
      found_q <= 1'b0;
      miss_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.enable) cnt_q <= CNT_W'(1);
        LOOKUP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (lookup_done) begin
            if (hit) begin
              age_q[idx] <= touch(age_q[idx], hit_way);
              hit_cnt_q  <= sat_inc(hit_cnt_q);
              if (!we_p0) begin
                data_out_q <= line_arr[idx][hit_way];
                found_q    <= 1'b1;
              end else begin
                mem_req_q <= 1'b1;
                mem_we_q  <= 1'b1;
              end
            end else begin
              miss_q     <= 1'b1;
              miss_cnt_q <= sat_inc(miss_cnt_q);
              mem_req_q  <= 1'b1;
              mem_we_q   <= we_p0;
            end
          end
        end
        MEM: if (bus.mem_done) begin
          mem_req_q <= 1'b0;
          found_q   <= 1'b1;
          if (!mem_we_q) begin
            valid_q[idx][victim] <= 1'b1;
            age_q[idx]           <= touch(age_q[idx], victim);
            data_out_q           <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Request capture and line storage
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.enable) begin
      addr_p0 <= bus.addr_in;
      we_p0   <= bus.we;
      data_p0 <= bus.data_in;
    end
    if (lookup_done && hit && we_p0)
      line_arr[idx][hit_way] <= data_p0;
    if (state_q == MEM && bus.mem_done && !mem_we_q) begin
      line_arr[idx][victim] <= bus.mem_rdata;
      tag_arr[idx][victim]  <= tag;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.found_data = found_q;
  assign bus.miss       = miss_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_p0;
  assign bus.mem_wdata  = data_p0;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_set_assoc_cache_lru.sv
// Bench for set_assoc_cache_lru: a DELAY=10 / STAT_W=16 instance driven from a vector table
// with a completion scoreboard, plus a DELAY=1 / STAT_W=2 instance for latency and saturation.
module tb_set_assoc_cache_lru;
  localparam int DLY = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  set_assoc_cache_lru_if #(.ADDR_LENGTH(10), .BLOCK_SIZE(32), .STAT_W(16)) bus ();
  set_assoc_cache_lru_if #(.ADDR_LENGTH(10), .BLOCK_SIZE(32), .STAT_W(2))  bus2 ();

  set_assoc_cache_lru #(.SIZE(128), .ADDR_LENGTH(10), .DELAY(DLY), .BLOCK_SIZE(32),
                        .ASSOCIATIVITY(4), .STAT_W(16))
    dut (.clk(clk), .reset(reset), .bus(bus));

  set_assoc_cache_lru #(.SIZE(128), .ADDR_LENGTH(10), .DELAY(1), .BLOCK_SIZE(32),
                        .ASSOCIATIVITY(4), .STAT_W(2))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int total = 0;
  int bad = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic fd_prev = 1'b0;
  logic ms_prev = 1'b0;

  // Completion monitor: every found_data pulse must match a pending expectation.
  always @(negedge clk) begin
    if (bus.found_data) begin
      chk("sb_pending", 64'(sb.size() != 0), 64'(1));
      chk("found_pulse_width", 64'(fd_prev), 64'(0));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk_data) chk("data_out", 64'(bus.data_out), 64'(e.data));
      end
    end
    if (bus.miss) chk("miss_pulse_width", 64'(ms_prev), 64'(0));
    fd_prev = bus.found_data;
    ms_prev = bus.miss;
  end

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_data;
    int          k;
  } vec_t;
  vec_t tbl[$];

  // Called at a negedge; returns at the negedge where found_data is visible.
  task automatic do_req(input logic w, input logic [9:0] a, input logic [31:0] d,
                        input logic eh, input logic [31:0] ed, input int k, input logic poke);
    int   n;
    logic held;
    sb.push_back('{chk_data: !w, data: ed});
    bus.enable  = 1'b1;
    bus.we      = w;
    bus.addr_in = a;
    bus.data_in = d;
    @(negedge clk);
    bus.enable  = 1'b0;
    bus.addr_in = 10'h3FC;
    bus.we      = ~w;
    n = 0;
    while (!(bus.found_data || bus.mem_req) && n < 40) begin
      bus.enable = poke && (n == 3);
      @(negedge clk);
      n++;
    end
    bus.enable = 1'b0;
    chk("latency", 64'(n), 64'(DLY));
    chk("hit", 64'(!bus.miss), 64'(eh));
    chk("mem_req_needed", 64'(bus.mem_req), 64'(w || !eh));
    if (eh) exp_hits++; else exp_misses++;
    if (bus.mem_req) begin
      chk("mem_we", 64'(bus.mem_we), 64'(w));
      chk("mem_addr", 64'(bus.mem_addr), 64'(a));
      if (w) chk("mem_wdata", 64'(bus.mem_wdata), 64'(d));
      held = 1'b1;
      repeat (k) begin
        @(negedge clk);
        held &= bus.mem_req & ~bus.found_data;
      end
      chk("mem_req_held", 64'(held), 64'(1));
      bus.mem_done  = 1'b1;
      bus.mem_rdata = 32'(a) + 32'h1000;
      @(negedge clk);
      bus.mem_done  = 1'b0;
      bus.mem_rdata = 32'hBAD0_BAD0;
      chk("mem_req_drop", 64'(bus.mem_req), 64'(0));
    end
    chk("found_data", 64'(bus.found_data), 64'(1));
    chk("busy_at_done", 64'(bus.busy), 64'(0));
    chk("hit_count", 64'(bus.hit_count), 64'(exp_hits));
    chk("miss_count", 64'(bus.miss_count), 64'(exp_misses));
  endtask

  task automatic req2(input logic [9:0] a, input logic eh, input logic [31:0] ed);
    int n;
    bus2.enable  = 1'b1;
    bus2.we      = 1'b0;
    bus2.addr_in = a;
    @(negedge clk);
    bus2.enable = 1'b0;
    n = 0;
    while (!(bus2.found_data || bus2.mem_req) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("d1_latency", 64'(n), 64'(1));
    chk("d1_hit", 64'(!bus2.miss), 64'(eh));
    if (bus2.mem_req) begin
      bus2.mem_done  = 1'b1;
      bus2.mem_rdata = 32'(a) + 32'h1000;
      @(negedge clk);
      bus2.mem_done = 1'b0;
    end
    chk("d1_found", 64'(bus2.found_data), 64'(1));
    chk("d1_data", 64'(bus2.data_out), 64'(ed));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    logic held;
    bus.enable = 1'b0;  bus.we = 1'b0;  bus.addr_in = '0;  bus.data_in = '0;
    bus.mem_done = 1'b0; bus.mem_rdata = '0;
    bus2.enable = 1'b0; bus2.we = 1'b0; bus2.addr_in = '0; bus2.data_in = '0;
    bus2.mem_done = 1'b0; bus2.mem_rdata = '0;

    tbl = '{
      '{1'b0, 10'h004, 32'h0,    1'b0, 32'h1004, 3},
      '{1'b0, 10'h004, 32'h0,    1'b1, 32'h1004, 0},
      '{1'b0, 10'h000, 32'h0,    1'b0, 32'h1000, 0},
      '{1'b0, 10'h010, 32'h0,    1'b0, 32'h1010, 1},
      '{1'b0, 10'h020, 32'h0,    1'b0, 32'h1020, 2},
      '{1'b0, 10'h030, 32'h0,    1'b0, 32'h1030, 5},
      '{1'b0, 10'h000, 32'h0,    1'b1, 32'h1000, 0},
      '{1'b0, 10'h040, 32'h0,    1'b0, 32'h1040, 1},
      '{1'b0, 10'h010, 32'h0,    1'b0, 32'h1010, 0},
      '{1'b0, 10'h000, 32'h0,    1'b1, 32'h1000, 0},
      '{1'b0, 10'h030, 32'h0,    1'b1, 32'h1030, 0},
      '{1'b0, 10'h040, 32'h0,    1'b1, 32'h1040, 0},
      '{1'b1, 10'h004, 32'hDEAD, 1'b1, 32'h0,    2},
      '{1'b0, 10'h004, 32'h0,    1'b1, 32'hDEAD, 0},
      '{1'b1, 10'h084, 32'hBEEF, 1'b0, 32'h0,    1},
      '{1'b0, 10'h084, 32'h0,    1'b0, 32'h1084, 0}
    };

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_found", 64'(bus.found_data), 64'(0));
    chk("rst_miss", 64'(bus.miss), 64'(0));
    chk("rst_mem_req", 64'(bus.mem_req), 64'(0));
    chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
    chk("rst_data_out", 64'(bus.data_out), 64'(0));
    chk("rst_hit_count", 64'(bus.hit_count), 64'(0));
    chk("rst_miss_count", 64'(bus.miss_count), 64'(0));

    // Vectors start back-to-back: each request is driven on the found_data cycle.
    foreach (tbl[i])
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_hit, tbl[i].exp_data,
             tbl[i].k, 1'b0);

    // Reset while waiting on the next level.
    bus.enable = 1'b1; bus.we = 1'b0; bus.addr_in = 10'h008;
    @(negedge clk);
    bus.enable = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mr_mem_req_up", 64'(bus.mem_req), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_mem_req_drop", 64'(bus.mem_req), 64'(0));
    chk("mr_busy", 64'(bus.busy), 64'(0));
    chk("mr_miss_count", 64'(bus.miss_count), 64'(0));
    chk("mr_data_out", 64'(bus.data_out), 64'(0));
    bus.mem_done = 1'b1; bus.mem_rdata = 32'h1008;
    @(negedge clk);
    bus.mem_done = 1'b0;
    chk("mr_late_done_found", 64'(bus.found_data), 64'(0));
    chk("mr_late_done_busy", 64'(bus.busy), 64'(0));
    exp_hits = 0;
    exp_misses = 0;
    do_req(1'b0, 10'h004, 32'h0, 1'b0, 32'h1004, 1, 1'b0);

    // enable pulsed mid-lookup must not start a second transaction.
    do_req(1'b0, 10'h004, 32'h0, 1'b1, 32'h1004, 0, 1'b1);
    held = 1'b1;
    repeat (15) begin
      @(negedge clk);
      held &= ~bus.busy & ~bus.mem_req;
    end
    chk("poke_ignored", 64'(held), 64'(1));
    chk("poke_hit_count", 64'(bus.hit_count), 64'(1));

    // DELAY=1 latency and 2-bit counter saturation.
    req2(10'h004, 1'b0, 32'h1004);
    repeat (4) req2(10'h004, 1'b1, 32'h1004);
    chk("sat_hit_count", 64'(bus2.hit_count), 64'(3));
    req2(10'h008, 1'b0, 32'h1008);
    req2(10'h00C, 1'b0, 32'h100C);
    req2(10'h104, 1'b0, 32'h1104);
    chk("sat_miss_count", 64'(bus2.miss_count), 64'(3));
    chk("sat_hit_count_hold", 64'(bus2.hit_count), 64'(3));

    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
